// File: rtl/hcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hcu_pkg
// Brief    : Shared constants, MD op codes and hazard helpers for the HCU.
// Revision : 1.0
// ============================================================================
package hcu_pkg;

    localparam logic [1:0] TUSE_NONE        = 2'd3;
    localparam int         DEF_MULT_CYCLES  = 5;
    localparam int         DEF_DIV_CYCLES   = 10;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
    endfunction

    // A producer only blocks a consumer that needs the value before it is ready.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (tuse != TUSE_NONE) && (wa == src) && (wa != 5'd0) && (tuse < tnew);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hcu_md_timer.sv
`default_nettype none
// ============================================================================
// Module   : hcu_md_timer
// Brief    : Multiply/divide busy timer; md_busy is high while cnt is nonzero.
// Revision : 1.0
// ============================================================================
module hcu_md_timer
    import hcu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       E_md_start,
    input  logic [1:0] E_md_op,
    output logic       md_busy
);

    generate
        if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
            $error("hcu_md_timer: MULT_CYCLES must be within 1..15");
        end
        if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
            $error("hcu_md_timer: DIV_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // A start while already counting cannot happen in a legal pipeline and is ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (E_md_start && (cnt_q == 4'd0)) begin
            cnt_d = md_is_div(E_md_op) ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != 4'd0);

endmodule
`default_nettype wire

// File: rtl/hcu_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hcu_stall_ctrl
// Brief    : Tuse/Tnew and MD-busy hazard unit; HCU_STAT_EN adds stall_cnt.
// Revision : 1.0
// ============================================================================
module hcu_stall_ctrl
    import hcu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic [1:0]  E_md_op,
    output logic        HCU_EN_IFU,
    output logic        HCU_EN_DREG,
    output logic        HCU_CLR_EREG,
    output logic        md_busy
`ifdef HCU_STAT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic rs_haz;
    logic rt_haz;
    logic md_haz;
    logic stall;

    hcu_md_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk        (clk),
        .reset      (reset),
        .E_md_start (E_md_start),
        .E_md_op    (E_md_op),
        .md_busy    (md_busy)
    );

    always_comb begin
        rs_haz = reg_hazard(D_rs_addr, D_tuse_rs, E_wa, E_tnew) ||
                 reg_hazard(D_rs_addr, D_tuse_rs, M_wa, M_tnew);
        rt_haz = reg_hazard(D_rt_addr, D_tuse_rt, E_wa, E_tnew) ||
                 reg_hazard(D_rt_addr, D_tuse_rt, M_wa, M_tnew);
        md_haz = D_is_md && (md_busy || E_md_start);
        // Reset is asynchronous, so it masks the stall combinationally too.
        stall  = reset && (rs_haz || rt_haz || md_haz);
    end

    assign HCU_EN_IFU   = !stall;
    assign HCU_EN_DREG  = !stall;
    assign HCU_CLR_EREG = stall;

`ifdef HCU_STAT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hcu_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hcu_stall_ctrl
// Brief    : Directed and random checks of hcu_stall_ctrl against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_hcu_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic [1:0]  E_md_op;
    logic        HCU_EN_IFU;
    logic        HCU_EN_DREG;
    logic        HCU_CLR_EREG;
    logic        md_busy;
`ifdef HCU_STAT_EN
    logic [31:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_from = 1;
    int busy_to   = 0;
    int obs_busy_cycles;
    int obs_stall_cycles;
    longint stat_exp = 0;

    hcu_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .D_rs_addr    (D_rs_addr),
        .D_rt_addr    (D_rt_addr),
        .D_tuse_rs    (D_tuse_rs),
        .D_tuse_rt    (D_tuse_rt),
        .D_is_md      (D_is_md),
        .E_wa         (E_wa),
        .E_tnew       (E_tnew),
        .M_wa         (M_wa),
        .M_tnew       (M_tnew),
        .E_md_start   (E_md_start),
        .E_md_op      (E_md_op),
        .HCU_EN_IFU   (HCU_EN_IFU),
        .HCU_EN_DREG  (HCU_EN_DREG),
        .HCU_CLR_EREG (HCU_CLR_EREG),
        .md_busy      (md_busy)
`ifdef HCU_STAT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit dep(input int src, input int tuse, input int wa, input int tnew);
        if (tuse == 3) return 1'b0;
        return (wa == src) && (wa != 0) && (tuse < tnew);
    endfunction

    function automatic bit model_busy(input int c);
        return (reset === 1'b1) && (c >= busy_from) && (c <= busy_to);
    endfunction

    task automatic set_in(input int rs, input int tus, input int rt, input int tut, input bit ismd,
                          input int ewa, input int etn, input int mwa, input int mtn,
                          input bit start, input int op);
        D_rs_addr = 5'(rs);  D_tuse_rs = 2'(tus);
        D_rt_addr = 5'(rt);  D_tuse_rt = 2'(tut);
        D_is_md   = ismd;
        E_wa      = 5'(ewa); E_tnew    = 2'(etn);
        M_wa      = 5'(mwa); M_tnew    = 2'(mtn);
        E_md_start = start;  E_md_op   = 2'(op);
    endtask

    // Inputs for cycle cyc are already applied; check at the falling edge, then advance.
    task automatic run_cycle();
        bit bm;
        bit st;
        @(negedge clk);
        bm = model_busy(cyc);
        st = (reset === 1'b1) &&
             (dep(D_rs_addr, D_tuse_rs, E_wa, E_tnew) || dep(D_rs_addr, D_tuse_rs, M_wa, M_tnew) ||
              dep(D_rt_addr, D_tuse_rt, E_wa, E_tnew) || dep(D_rt_addr, D_tuse_rt, M_wa, M_tnew) ||
              (D_is_md && (bm || E_md_start)));
        chk("md_busy",      32'(md_busy),      32'(bm));
        chk("HCU_EN_IFU",   32'(HCU_EN_IFU),   32'(!st));
        chk("HCU_EN_DREG",  32'(HCU_EN_DREG),  32'(!st));
        chk("HCU_CLR_EREG", 32'(HCU_CLR_EREG), 32'(st));
        chk("no_start_while_busy", 32'(E_md_start && md_busy), 32'd0);
        if (md_busy === 1'b1) obs_busy_cycles++;
        if (HCU_EN_IFU === 1'b0) obs_stall_cycles++;
`ifdef HCU_STAT_EN
        chk("stall_cnt", stall_cnt, 32'(stat_exp));
`endif
        if (reset !== 1'b1) begin
            stat_exp  = 0;
            busy_from = 1;
            busy_to   = 0;
        end else begin
            if (st && stat_exp < 64'hFFFF_FFFF) stat_exp++;
            if (E_md_start && !bm) begin
                busy_from = cyc + 1;
                busy_to   = cyc + ((E_md_op >= 2'd2) ? 10 : 5);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b0;
        set_in(5, 0, 7, 0, 1'b1, 5, 2, 7, 2, 1'b1, 0);
        @(posedge clk);
        #1;
        // Reset held with hazard-looking inputs: enables forced high.
        run_cycle();
        run_cycle();

        reset = 1'b1;
        set_in(0, 3, 0, 3, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        run_cycle();

        // rs dependency on E, then tuse equal to tnew
        set_in(5, 1, 0, 3, 1'b0, 5, 2, 0, 0, 1'b0, 0);
        run_cycle();
        chk("rs_E_stall_ifu", 32'(HCU_EN_IFU), 32'd0);
        set_in(5, 2, 0, 3, 1'b0, 5, 2, 0, 0, 1'b0, 0);
        run_cycle();
        chk("rs_E_nostall_ifu", 32'(HCU_EN_IFU), 32'd1);

        // $0 never stalls; rt dependency on M does
        set_in(0, 0, 0, 3, 1'b0, 0, 2, 0, 0, 1'b0, 0);
        run_cycle();
        set_in(1, 3, 7, 0, 1'b0, 0, 0, 7, 1, 1'b0, 0);
        run_cycle();
        chk("rt_M_stall_clr", 32'(HCU_CLR_EREG), 32'd1);

        // mult: held t..t+5, released at t+6
        obs_busy_cycles = 0;
        obs_stall_cycles = 0;
        set_in(0, 3, 0, 3, 1'b1, 0, 0, 0, 0, 1'b1, 0);
        run_cycle();
        E_md_start = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle();
        chk("mult_hold_len", 32'(obs_stall_cycles), 32'd6);
        run_cycle();
        chk("mult_release", 32'(HCU_EN_IFU), 32'd1);
        chk("mult_busy_len", 32'(obs_busy_cycles), 32'd5);

        // div with a non-MD D instruction during busy
        obs_busy_cycles = 0;
        set_in(0, 3, 0, 3, 1'b0, 0, 0, 0, 0, 1'b1, 2);
        run_cycle();
        E_md_start = 1'b0;
        for (int i = 0; i < 11; i++) run_cycle();
        chk("div_busy_len", 32'(obs_busy_cycles), 32'd10);

        // divu, asynchronous reset mid-count
        set_in(0, 3, 0, 3, 1'b1, 0, 0, 0, 0, 1'b1, 3);
        run_cycle();
        E_md_start = 1'b0;
        run_cycle();
        run_cycle();
        #1;
        chk("pre_reset_busy", 32'(md_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(md_busy), 32'd0);
        chk("async_rst_en", 32'(HCU_EN_IFU), 32'd1);
        run_cycle();
        run_cycle();

        // release with a mult accepted on the first edge
        obs_busy_cycles = 0;
        reset = 1'b1;
        set_in(0, 3, 0, 3, 1'b1, 0, 0, 0, 0, 1'b1, 1);
        run_cycle();
        E_md_start = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle();
        chk("post_rst_mult_len", 32'(obs_busy_cycles), 32'd5);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit can_start;
            can_start = !model_busy(cyc);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   can_start && ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
